// File: rtl/altavoz_axi_slave_if.sv
// ---------------------------------------------------------------------------
// altavoz_axi_slave_if
// AXI4-Lite bus bundle for the altavoz tone generator register block.
//
// Signals (as seen from the slave):
//   awaddr/awprot/awvalid -> awready   write address channel
//   wdata/wstrb/wvalid    -> wready    write data channel
//   bresp/bvalid          <- bready    write response channel
//   araddr/arprot/arvalid -> arready   read address channel
//   rdata/rresp/rvalid    <- rready    read data channel
// ---------------------------------------------------------------------------
interface altavoz_axi_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                        awprot;
    logic                              awvalid;
    logic                              awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                        arprot;
    logic                              arvalid;
    logic                              arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                        rresp;
    logic                              rvalid;
    logic                              rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/altavoz_axi_slave.sv
// ---------------------------------------------------------------------------
// altavoz_axi_slave
// AXI4-Lite register block driving a square-wave speaker tone generator.
//
// Registers (word index = addr[3:2]):
//   0 CTRL     bit0 EN, remaining bits scratch (RW)
//   1 PERIOD   half-period in clocks (RW)
//   2 DURATION tone length in clocks, 0 = continuous (RW)
//   3 STATUS   bit0 BUSY, bit1 speaker_out (RO)
//
// Ports:
//   s00_axi_aclk     clock, all logic on rising edge
//   s00_axi_aresetn  asynchronous active-low reset
//   s00_axi          AXI4-Lite slave bus (altavoz_axi_slave_if.slave)
//   speaker_out      square-wave speaker drive
// ---------------------------------------------------------------------------
module altavoz_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    altavoz_axi_slave_if.slave     s00_axi,
    output logic                   speaker_out
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Merge new data into an old word, byte by byte, under the write strobes.
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]     old_val,
                                                 input logic [DW-1:0]     new_val,
                                                 input logic [STRB_W-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    // Reset asserts immediately but releases only after two clean clock edges,
    // so no flop leaves reset on a metastable deassertion.
    logic rst_meta;
    logic rst_n_sync;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] period_q;
    logic [DW-1:0] duration_q;
    logic [0:0]    state_q;
    logic [31:0]   hcnt_q;
    logic [31:0]   dcnt_q;
    logic          spk_q;

    logic          aw_ready_q;
    logic          bvalid_q;
    logic          ar_ready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    logic          wr_fire;
    logic          rd_fire;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic          en;
    logic          hw_stop;
    logic [DW-1:0] ctrl_hw;
    logic [DW-1:0] status_w;
    logic [DW-1:0] rd_word;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    // AW and W are accepted together on the edge where the ready pulse is high.
    assign wr_fire = aw_ready_q && s00_axi.awvalid && s00_axi.wvalid;
    assign rd_fire = ar_ready_q && s00_axi.arvalid;
    assign wr_idx  = s00_axi.awaddr[3:2];
    assign rd_idx  = s00_axi.araddr[3:2];

    assign en       = ctrl_q[0];
    assign hw_stop  = (state_q == ST_RUN) && (duration_q != '0) &&
                      (dcnt_q == duration_q - 32'd1);
    assign status_w = {{(DW-2){1'b0}}, spk_q, (state_q == ST_RUN)};

    // Hardware EN clear on tone expiry; a same-cycle software write is
    // merged on top of this, so software-written bytes take priority.
    always_comb begin
        ctrl_hw = ctrl_q;
        if (hw_stop) ctrl_hw[0] = 1'b0;
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            2'd0:    rd_word = ctrl_q;
            2'd1:    rd_word = period_q;
            2'd2:    rd_word = duration_q;
            default: rd_word = status_w;
        endcase
    end

    // ---- register file ----
    always_ff @(posedge s00_axi_aclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            duration_q <= '0;
        end else begin
            if (wr_fire && wr_idx == 2'd0)
                ctrl_q <= apply_strb(ctrl_hw, s00_axi.wdata, s00_axi.wstrb);
            else
                ctrl_q <= ctrl_hw;
            if (wr_fire && wr_idx == 2'd1)
                period_q <= apply_strb(period_q, s00_axi.wdata, s00_axi.wstrb);
            if (wr_fire && wr_idx == 2'd2)
                duration_q <= apply_strb(duration_q, s00_axi.wdata, s00_axi.wstrb);
        end
    end

    // ---- write channel handshake ----
    always_ff @(posedge s00_axi_aclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            if (!aw_ready_q && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q)
                aw_ready_q <= 1'b1;
            else
                aw_ready_q <= 1'b0;
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (bvalid_q && s00_axi.bready)
                bvalid_q <= 1'b0;
        end
    end

    // ---- read channel handshake ----
    always_ff @(posedge s00_axi_aclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (!ar_ready_q && s00_axi.arvalid && !rvalid_q)
                ar_ready_q <= 1'b1;
            else
                ar_ready_q <= 1'b0;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && s00_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // ---- tone FSM ----
    always_ff @(posedge s00_axi_aclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            dcnt_q  <= '0;
            spk_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hcnt_q <= '0;
                    dcnt_q <= '0;
                    spk_q  <= 1'b0;
                    if (en && period_q != '0) state_q <= ST_RUN;
                end
                default: begin
                    if (!en || period_q == '0 || hw_stop) begin
                        state_q <= ST_IDLE;
                        hcnt_q  <= '0;
                        dcnt_q  <= '0;
                        spk_q   <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 32'd1;
                        // >= rather than == so a PERIOD lowered mid-tone
                        // takes effect at once instead of waiting for a wrap.
                        if (hcnt_q >= period_q - 32'd1) begin
                            hcnt_q <= '0;
                            spk_q  <= ~spk_q;
                        end else begin
                            hcnt_q <= hcnt_q + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign s00_axi.awready = aw_ready_q;
    assign s00_axi.wready  = aw_ready_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.arready = ar_ready_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid_q;
    assign speaker_out     = spk_q;

endmodule

// File: tb/tb_altavoz_axi_slave.sv
module tb_altavoz_axi_slave;
    logic clk;
    logic aresetn;
    logic speaker_out;

    int total = 0;
    int bad   = 0;

    altavoz_axi_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

    altavoz_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi         (bus),
        .speaker_out     (speaker_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Speaker and handshake monitor, sampled on the falling edge.
    logic prev_spk  = 1'b0;
    int   cyc       = 0;
    int   rise_cnt  = 0;
    int   last_rise = 0;
    int   rise_gap  = 0;
    int   high_run  = 0;
    int   last_high = 0;
    int   aw_pulses = 0;

    always @(negedge clk) begin
        if (speaker_out && !prev_spk) begin
            if (rise_cnt > 0) rise_gap = cyc - last_rise;
            last_rise = cyc;
            rise_cnt++;
        end
        if (speaker_out) high_run++;
        else if (prev_spk) begin
            last_high = high_run;
            high_run  = 0;
        end
        if (bus.awready) aw_pulses++;
        prev_spk = speaker_out;
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.awready) check("aw_timeout", {31'b0, bus.awready}, 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.bvalid) check("b_timeout", {31'b0, bus.bvalid}, 32'd1);
        check("bresp", {30'b0, bus.bresp}, 32'd0);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.arready) check("ar_timeout", {31'b0, bus.arready}, 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.rvalid) check("r_timeout", {31'b0, bus.rvalid}, 32'd1);
        check("rresp", {30'b0, bus.rresp}, 32'd0);
        d = bus.rdata;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    logic [31:0] rd;
    int r0;
    int p0;
    int n;

    initial begin
        aresetn = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'b0, bus.awready}, 32'd0);
        check("rst_wready",  {31'b0, bus.wready},  32'd0);
        check("rst_bvalid",  {31'b0, bus.bvalid},  32'd0);
        check("rst_arready", {31'b0, bus.arready}, 32'd0);
        check("rst_rvalid",  {31'b0, bus.rvalid},  32'd0);
        check("rst_rdata",   bus.rdata,            32'd0);
        check("rst_spk",     {31'b0, speaker_out}, 32'd0);
        aresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        axi_read(4'h0, rd); check("rst_ctrl",     rd, 32'd0);
        axi_read(4'h4, rd); check("rst_period",   rd, 32'd0);
        axi_read(4'h8, rd); check("rst_duration", rd, 32'd0);
        axi_read(4'hC, rd); check("rst_status",   rd, 32'd0);

        // Basic write/readback, STATUS write discarded, BUSY visible
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        axi_read(4'h8, rd); check("rb_duration", rd, 32'd3);
        axi_read(4'h4, rd); check("rb_period",   rd, 32'd2);
        axi_write(4'h8, 32'd0, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        axi_write(4'hC, 32'd4, 4'hF);
        axi_read(4'h0, rd); check("rb_ctrl", rd, 32'd1);
        axi_read(4'hC, rd); check("status_busy", rd & 32'hFFFF_FFFD, 32'd1);

        // Continuous tone, PERIOD=5 -> 10-clock period, 5 clocks high
        axi_write(4'h4, 32'd5, 4'hF);
        repeat (40) @(posedge clk);
        #1;
        check("p5_gap",  rise_gap,  32'd10);
        check("p5_high", last_high, 32'd5);
        axi_write(4'h0, 32'd0, 4'hF);
        check("p5_off_spk", {31'b0, speaker_out}, 32'd0);
        axi_read(4'hC, rd); check("p5_off_status", rd, 32'd0);

        // Timed tone, PERIOD=3 DURATION=30 -> 5 full periods, EN cleared
        axi_write(4'h4, 32'd3, 4'hF);
        axi_write(4'h8, 32'd30, 4'hF);
        r0 = rise_cnt;
        axi_write(4'h0, 32'd1, 4'hF);
        repeat (80) @(posedge clk);
        #1;
        check("d30_rises", rise_cnt - r0, 32'd5);
        check("d30_gap",   rise_gap,      32'd6);
        check("d30_spk",   {31'b0, speaker_out}, 32'd0);
        axi_read(4'hC, rd); check("d30_status", rd, 32'd0);
        axi_read(4'h0, rd); check("d30_ctrl",   rd, 32'd0);

        // Byte strobes
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h4, 32'hAABB_CCDD, 4'b0010);
        axi_read(4'h4, rd); check("strb_period", rd, 32'h0000_CC00);
        axi_write(4'h0, 32'h1234_5670, 4'hF);
        axi_write(4'h0, 32'hAB00_0000, 4'b1000);
        axi_read(4'h0, rd); check("strb_ctrl", rd, 32'hAB34_5670);
        axi_write(4'h0, 32'd0, 4'hF);

        // AW before W, stalled B: single accept, no duplicate write
        @(posedge clk); #1;
        p0 = aw_pulses;
        bus.awaddr = 4'h8; bus.awvalid = 1'b1;
        bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("aw_only_ready", {31'b0, bus.awready}, 32'd0);
        end
        bus.wvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.awready) check("stall_aw_timeout", {31'b0, bus.awready}, 32'd1);
        @(posedge clk); #1;
        bus.wdata = 32'hDEAD;
        for (int i = 0; i < 4; i++) begin
            check("stall_bvalid",  {31'b0, bus.bvalid},  32'd1);
            check("stall_awready", {31'b0, bus.awready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check("stall_bvalid_drop", {31'b0, bus.bvalid}, 32'd0);
        check("stall_pulses", aw_pulses - p0, 32'd1);
        axi_read(4'h8, rd); check("stall_data", rd, 32'h55);

        // Reset while tone running and read response pending
        axi_write(4'h4, 32'd5, 4'hF);
        axi_write(4'h8, 32'd0, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        n = 0;
        while (!speaker_out && n < 30) begin @(posedge clk); #1; n++; end
        check("arst_tone_on", {31'b0, speaker_out}, 32'd1);
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        check("arst_rvalid_pre", {31'b0, bus.rvalid}, 32'd1);
        check("arst_rdata_pre",  bus.rdata,           32'd5);
        aresetn = 1'b0;
        #1;
        check("arst_spk",     {31'b0, speaker_out}, 32'd0);
        check("arst_rvalid",  {31'b0, bus.rvalid},  32'd0);
        check("arst_rdata",   bus.rdata,            32'd0);
        check("arst_arready", {31'b0, bus.arready}, 32'd0);
        check("arst_bvalid",  {31'b0, bus.bvalid},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rvalid", {31'b0, bus.rvalid}, 32'd0);
        check("post_bvalid", {31'b0, bus.bvalid}, 32'd0);
        check("post_spk",    {31'b0, speaker_out}, 32'd0);
        axi_read(4'h0, rd); check("post_ctrl",   rd, 32'd0);
        axi_read(4'h4, rd); check("post_period", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
